// File: rtl/bram_sdp_clr.sv
// Simple dual-port block RAM with byte enables, selectable read latency,
// optional write-to-read bypass and a post-reset zero-fill controller.
module bram_sdp_clr #(
  parameter int DWIDTH         = 16,
  parameter int AWIDTH         = 9,
  parameter int DEPTH          = 512,
  parameter int BWIDTH         = 8,
  parameter int READ_LATENCY   = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DWIDTH-1:0]          data,
  input  logic [DWIDTH/BWIDTH-1:0]   byteena,
  input  logic [AWIDTH-1:0]          wraddress,
  input  logic                       wren,
  input  logic [AWIDTH-1:0]          rdaddress,
  input  logic                       rden,
  output logic [DWIDTH-1:0]          q,
  output logic                       qvalid,
  output logic                       init_done
);

  localparam int NBYTES = DWIDTH / BWIDTH;
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;
  localparam logic [AWIDTH:0]   DEPTH_W  = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADR = AWIDTH'(DEPTH - 1);

  if (DEPTH > 2 ** AWIDTH) begin : g_bad_depth
    $fatal(1, "bram_sdp_clr: DEPTH exceeds 2**AWIDTH");
  end
  if (DWIDTH % BWIDTH != 0) begin : g_bad_bwidth
    $fatal(1, "bram_sdp_clr: DWIDTH is not a multiple of BWIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "bram_sdp_clr: READ_LATENCY must be 1 or 2");
  end

  logic [DWIDTH-1:0] mem [DEPTH];
  logic              state;
  logic [AWIDTH-1:0] clr_cnt;

  logic              ready;
  logic              wr_hit;
  logic              rd_ok;
  logic              rd_in_range;
  logic [DWIDTH-1:0] rd_word;

  logic              p1_valid;
  logic [DWIDTH-1:0] p1_data;
  logic              q_r;
  logic [DWIDTH-1:0] q_data;

  assign ready       = (state == ST_READY);
  assign wr_hit      = ready && wren && ({1'b0, wraddress} < DEPTH_W);
  assign rd_ok       = ready && rden;
  assign rd_in_range = ({1'b0, rdaddress} < DEPTH_W);

  // Controller: reset restarts the zero-fill from address 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      // NOTE: non-blocking assignments on every register so all flops see
      // pre-edge values regardless of statement order.
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == LAST_ADR) state <= ST_READY;
    end
  end

  // NOTE: the array has no reset branch so it can map onto block RAM;
  // zeroing is done one word per cycle by the CLEAR state instead.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (!ready) begin
        mem[clr_cnt] <= '0;
      end else if (wr_hit) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (byteena[i]) mem[wraddress][i*BWIDTH +: BWIDTH] <= data[i*BWIDTH +: BWIDTH];
        end
      end
    end
  end

  // Read word, optionally merged with a same-cycle write to the same address.
  always_comb begin
    rd_word = rd_in_range ? mem[rdaddress] : '0;
    if (BYPASS != 0 && wr_hit && wraddress == rdaddress) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (byteena[i]) rd_word[i*BWIDTH +: BWIDTH] = data[i*BWIDTH +: BWIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p1_valid <= 1'b0;
      p1_data  <= '0;
      q_r      <= 1'b0;
      q_data   <= '0;
    end else begin
      p1_valid <= rd_ok;
      if (rd_ok) p1_data <= rd_word;
      if (READ_LATENCY == 1) begin
        q_r <= rd_ok;
        if (rd_ok) q_data <= rd_word;
      end else begin
        q_r <= p1_valid;
        if (p1_valid) q_data <= p1_data;
      end
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign q         = reset ? '0 : q_data;
  assign qvalid    = !reset && q_r;
  assign init_done = !reset && ready;

endmodule

// File: tb/tb_bram_sdp_clr.sv
// Directed bench: a default instance (latency 1, bypass) and a small
// instance (DEPTH 300, latency 2, no bypass) driven by the same stimulus.
module tb_bram_sdp_clr;

  logic        clock;
  logic        reset;
  logic [15:0] data;
  logic [1:0]  byteena;
  logic [8:0]  wraddress;
  logic        wren;
  logic [8:0]  rdaddress;
  logic        rden;
  logic [15:0] q1, q2;
  logic        qv1, qv2, id1, id2;

  int n_checks = 0;
  int n_fail   = 0;

  bram_sdp_clr dut (
    .clock(clock), .reset(reset), .data(data), .byteena(byteena),
    .wraddress(wraddress), .wren(wren), .rdaddress(rdaddress), .rden(rden),
    .q(q1), .qvalid(qv1), .init_done(id1)
  );

  bram_sdp_clr #(
    .DWIDTH(16), .AWIDTH(9), .DEPTH(300), .BWIDTH(8),
    .READ_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(1)
  ) dut2 (
    .clock(clock), .reset(reset), .data(data), .byteena(byteena),
    .wraddress(wraddress), .wren(wren), .rdaddress(rdaddress), .rden(rden),
    .q(q2), .qvalid(qv2), .init_done(id2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [8:0] a, input logic [15:0] d, input logic [1:0] be);
    wren = 1'b1; wraddress = a; data = d; byteena = be;
    tick;
    wren = 1'b0;
  endtask

  // Runs the 512-cycle clear window, pulsing rden early on, and records the
  // first cycle each instance reports init_done plus any stray qvalid.
  task automatic clear_window(output int first1, output int first2, output int qvc);
    first1 = 0; first2 = 0; qvc = 0;
    for (int i = 1; i <= 512; i++) begin
      tick;
      if (id1 && first1 == 0) first1 = i;
      if (id2 && first2 == 0) first2 = i;
      if (qv1 || qv2) qvc++;
      rden      = (i < 200) && (i % 3 == 0);
      rdaddress = 9'(i);
    end
    rden = 1'b0;
  endtask

  int f1, f2, qc;

  initial begin
    reset = 1'b1; data = '0; byteena = '0; wraddress = '0; wren = 1'b0;
    rdaddress = '0; rden = 1'b0;
    tick;
    check("rst_q1", q1, 0);
    check("rst_qv1", qv1, 0);
    check("rst_id1", id1, 0);
    check("rst_q2", q2, 0);
    check("rst_id2", id2, 0);
    reset = 1'b0;

    clear_window(f1, f2, qc);
    check("clr_done_cycle_512", f1, 512);
    check("clr_done_cycle_300", f2, 300);
    check("clr_no_qvalid", qc, 0);

    // Read of a cleared word.
    rden = 1'b1; rdaddress = 9'd5;
    tick;
    rden = 1'b0;
    check("rd5_q1", q1, 16'h0000);
    check("rd5_qv1", qv1, 1);
    check("rd5_qv2_early", qv2, 0);
    tick;
    check("rd5_qv1_pulse", qv1, 0);
    check("rd5_qv2", qv2, 1);
    check("rd5_q2", q2, 16'h0000);

    // Full write then read next cycle.
    write(9'd3, 16'hABCD, 2'b11);
    rden = 1'b1; rdaddress = 9'd3;
    tick;
    rden = 1'b0;
    check("wr3_q1", q1, 16'hABCD);
    check("wr3_qv1", qv1, 1);
    tick;
    check("wr3_qv1_low", qv1, 0);
    check("wr3_q1_hold", q1, 16'hABCD);
    check("wr3_q2", q2, 16'hABCD);
    check("wr3_qv2", qv2, 1);
    tick;
    check("wr3_qv2_low", qv2, 0);
    check("wr3_q2_hold", q2, 16'hABCD);

    // Low-lane-only write.
    write(9'd3, 16'h1234, 2'b01);
    rden = 1'b1; rdaddress = 9'd3;
    tick;
    rden = 1'b0;
    check("be01_q1", q1, 16'hAB34);
    tick;
    check("be01_q2", q2, 16'hAB34);

    // Same-cycle read and write of one address.
    write(9'd7, 16'h1111, 2'b11);
    wren = 1'b1; wraddress = 9'd7; data = 16'h2222; byteena = 2'b10;
    rden = 1'b1; rdaddress = 9'd7;
    tick;
    wren = 1'b0; rden = 1'b0;
    check("rw_bypass_q1", q1, 16'h2211);
    check("rw_bypass_qv1", qv1, 1);
    tick;
    check("rw_nobypass_q2", q2, 16'h1111);
    check("rw_nobypass_qv2", qv2, 1);
    rden = 1'b1; rdaddress = 9'd7;
    tick;
    rden = 1'b0;
    check("rw_later_q1", q1, 16'h2211);
    tick;
    check("rw_later_q2", q2, 16'h2211);

    // Back-to-back reads.
    rden = 1'b1; rdaddress = 9'd3;
    tick;
    check("b2b_a_q1", q1, 16'hAB34);
    check("b2b_a_qv1", qv1, 1);
    rdaddress = 9'd7;
    tick;
    rden = 1'b0;
    check("b2b_b_q1", q1, 16'h2211);
    check("b2b_b_qv1", qv1, 1);
    check("b2b_a_q2", q2, 16'hAB34);
    check("b2b_a_qv2", qv2, 1);
    tick;
    check("b2b_end_qv1", qv1, 0);
    check("b2b_b_q2", q2, 16'h2211);
    check("b2b_b_qv2", qv2, 1);

    // Address 400 is beyond DEPTH for the small instance only.
    write(9'd299, 16'h5A5A, 2'b11);
    write(9'd400, 16'hFFFF, 2'b11);
    rden = 1'b1; rdaddress = 9'd400;
    tick;
    rden = 1'b0;
    check("oor_q1_in_range", q1, 16'hFFFF);
    tick;
    check("oor_q2_zero", q2, 16'h0000);
    check("oor_qv2", qv2, 1);
    rden = 1'b1; rdaddress = 9'd299;
    tick;
    rden = 1'b0;
    check("a299_q1", q1, 16'h5A5A);
    tick;
    check("a299_q2_unchanged", q2, 16'h5A5A);

    // Reset while a latency-2 read is in flight.
    rden = 1'b1; rdaddress = 9'd3;
    tick;
    rden = 1'b0; reset = 1'b1;
    tick;
    check("rst2_qv2_dropped", qv2, 0);
    check("rst2_q2", q2, 0);
    check("rst2_q1", q1, 0);
    check("rst2_id1", id1, 0);
    reset = 1'b0;
    tick;
    check("rst2_qv2_after", qv2, 0);

    // Reset again at clear count 100 with reads pulsed during the clear.
    qc = 0;
    for (int i = 2; i <= 100; i++) begin
      rden = i[0];
      tick;
      if (qv1 || qv2) qc++;
    end
    rden = 1'b0;
    check("clr100_no_qvalid", qc, 0);
    reset = 1'b1;
    tick;
    check("rst3_id1", id1, 0);
    check("rst3_qv1", qv1, 0);
    reset = 1'b0;

    clear_window(f1, f2, qc);
    check("reclr_done_cycle_512", f1, 512);
    check("reclr_done_cycle_300", f2, 300);
    check("reclr_no_qvalid", qc, 0);

    // Previously written words must read back zero.
    rden = 1'b1; rdaddress = 9'd3;
    tick;
    check("reclr_a3_q1", q1, 0);
    check("reclr_a3_qv1", qv1, 1);
    rdaddress = 9'd7;
    tick;
    check("reclr_a7_q1", q1, 0);
    check("reclr_a3_q2", q2, 0);
    rdaddress = 9'd400;
    tick;
    check("reclr_a400_q1", q1, 0);
    rdaddress = 9'd299;
    tick;
    rden = 1'b0;
    check("reclr_a299_q1", q1, 0);
    tick;
    check("reclr_a299_q2", q2, 0);
    check("reclr_a299_qv2", qv2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
